fetch_queue: RTL and testbench

Parametrised instruction fetch queue between the instruction SRAM-like port and the decode stage of the 5-stage MIPS pipeline. It buffers fetched words with their PC, delay-slot flag and fetch address-error flag. Fetch stalls are decoupled from decode stalls, and the fetch side issues requests against a credit count. On a pipeline flush (exception, eret, branch redirect), responses still in flight are discarded, so wrong-path instructions never reach decode.

---
 rtl/fetchq_pkg.sv | 21 ++
 rtl/fetch_queue_if.sv | 35 +++
 rtl/fetchq_ram.sv | 31 +++
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetchq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The entry layout {pc, instr, bd, adel} matches the packing used inside fetch_queue.
package fetchq_pkg;

    localparam int FETCHQ_DATA_W = 32;
    localparam int FETCHQ_ADDR_W = 32;

    typedef struct packed {
        logic [FETCHQ_ADDR_W-1:0] pc;
        logic [FETCHQ_DATA_W-1:0] instr;
        logic                     bd;
        logic                     adel;
    } fetchq_entry_t;

    localparam int FETCHQ_ENTRY_W = $bits(fetchq_entry_t);

    // Cause code for a fetch address error.
    // except_type raises it downstream when pop_adel is set.
    localparam logic [4:0] FETCHQ_EXC_ADEL = 5'h04;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle for the fetch queue.
// The slave modport is used by the queue.
// The master modport is used by the fetch unit and decode environment.
interface fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_fire;
    logic              req_ok;
    logic              push_valid;
    logic              push_ready;
    logic [ADDR_W-1:0] push_pc;
    logic [DATA_W-1:0] push_instr;
    logic              push_bd;
    logic              push_adel;
    logic              pop_valid;
    logic              pop_ready;
    logic [ADDR_W-1:0] pop_pc;
    logic [DATA_W-1:0] pop_instr;
    logic              pop_bd;
    logic              pop_adel;
    logic              flush;

    modport slave (
        input  req_fire, push_valid, push_pc, push_instr, push_bd, push_adel,
        input  pop_ready, flush,
        output req_ok, push_ready, pop_valid, pop_pc, pop_instr, pop_bd, pop_adel
    );

    modport master (
        output req_fire, push_valid, push_pc, push_instr, push_bd, push_adel,
        output pop_ready, flush,
        input  req_ok, push_ready, pop_valid, pop_pc, pop_instr, pop_bd, pop_adel
    );
endinterface

// File: rtl/fetchq_ram.sv
// Storage array for the fetch queue.
// It has one synchronous write port and one combinational read port.
// All entries are cleared on reset, so the head reads as zero after reset.
module fetchq_ram
    import fetchq_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = FETCHQ_ENTRY_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the instruction memory port and decode.
//
// Fetch requests are issued against a credit count, so every response is
// guaranteed a slot in the queue. On a flush, the responses still in flight
// are counted in drop_cnt and discarded as they arrive.
//
// Optional feature: define FETCHQ_BYPASS_EN to forward a response straight
// to decode in the same cycle when the queue is empty and decode is ready.
module fetch_queue
    import fetchq_pkg::*;
#(
    parameter  int DATA_W       = 32,
    parameter  int ADDR_W       = 32,
    parameter  int DEPTH        = 4,
    parameter  int MAX_INFLIGHT = 2,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    fetch_queue_if.slave     bus,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int IF_W    = $clog2(MAX_INFLIGHT + 1);
    localparam int SUM_W   = CNT_W + IF_W;
    localparam int ENTRY_W = ADDR_W + DATA_W + 2;

    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [IF_W-1:0]    inflight, inflight_next;
    logic [IF_W-1:0]    drop_cnt, drop_next;
    logic [IF_W:0]      drop_base, drop_diff;
    logic               dropping, full, head_valid;
    logic               push_acc, do_write, do_pop, bypass_hit;
    logic [ENTRY_W-1:0] wr_entry, head_entry;

    assign dropping = (drop_cnt != '0);
    assign full     = (count == CNT_W'(DEPTH));

    // Credit check: every outstanding request must already own a free slot.
    assign bus.req_ok = !rst && (inflight < IF_W'(MAX_INFLIGHT))
                      && ((SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH));

    // While dropping, responses are always taken because they are discarded.
    assign bus.push_ready = !rst && (dropping || !full);
    assign push_acc       = bus.push_valid && bus.push_ready && !dropping && !bus.flush;

`ifdef FETCHQ_BYPASS_EN
    assign bypass_hit = push_acc && (count == '0) && bus.pop_ready;
`else
    assign bypass_hit = 1'b0;
`endif

    assign do_write   = push_acc && !bypass_hit;
    assign head_valid = !rst && !bus.flush && (count != '0);
    assign do_pop     = head_valid && bus.pop_ready;
    assign wr_entry   = {bus.push_pc, bus.push_instr, bus.push_bd, bus.push_adel};

    fetchq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (do_write),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head_entry)
    );

    assign bus.pop_valid = head_valid || bypass_hit;
    assign {bus.pop_pc, bus.pop_instr, bus.pop_bd, bus.pop_adel} =
        bypass_hit ? wr_entry : head_entry;

    // Next in-flight and drop counts.
    // A flush turns all outstanding requests, plus any fired this cycle, into drops.
    always_comb begin
        inflight_next = inflight + IF_W'(bus.req_fire) - IF_W'(bus.push_valid);
        drop_base     = {1'b0, inflight} + (IF_W + 1)'(bus.req_fire);
        drop_diff     = drop_base - (IF_W + 1)'(bus.push_valid);
        drop_next     = drop_cnt;
        if (bus.flush) begin
            drop_next = (bus.push_valid && drop_base == '0) ? '0 : drop_diff[IF_W-1:0];
        end else if (dropping && bus.push_valid) begin
            drop_next = drop_cnt - IF_W'(1);
        end
    end

    // Pointer, occupancy and credit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            drop_cnt <= drop_next;
            if (bus.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)   rd_ptr <= rd_ptr + PTR_W'(1);
                if (do_write && !do_pop)      count <= count + CNT_W'(1);
                else if (!do_write && do_pop) count <= count - CNT_W'(1);
            end
        end
    end

    // A response with nothing outstanding means the memory side broke protocol.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        !(bus.push_valid && inflight == '0 && !bus.req_fire));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue with a scoreboard.
// Expected entries are queued as responses are issued.
// A negedge monitor compares every pop handshake against the head of that queue.
module tb_fetch_queue;
    import fetchq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count;
    int         total = 0;
    int         bad   = 0;

    fetchq_entry_t exp_q[$];
    fetchq_entry_t mon_e;

    fetch_queue_if #(.DATA_W(32), .ADDR_W(32)) fq ();

    fetch_queue #(
        .DATA_W       (32),
        .ADDR_W       (32),
        .DEPTH        (4),
        .MAX_INFLIGHT (2)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (fq),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        fq.req_fire   = 1'b0;
        fq.push_valid = 1'b0;
        fq.pop_ready  = 1'b0;
        fq.flush      = 1'b0;
        fq.push_pc    = '0;
        fq.push_instr = '0;
        fq.push_bd    = 1'b0;
        fq.push_adel  = 1'b0;
    endtask

    // Drive one cycle of inputs; kept responses go into the scoreboard.
    task automatic drive(input bit rf, input bit pv, input bit pr, input bit fl,
                         input logic [31:0] pc, input logic [31:0] instr, input bit keep);
        fetchq_entry_t e;
        fq.req_fire   = rf;
        fq.push_valid = pv;
        fq.pop_ready  = pr;
        fq.flush      = fl;
        fq.push_pc    = pc;
        fq.push_instr = instr;
        fq.push_bd    = pc[2];
        fq.push_adel  = pc[3];
        if (fl) exp_q.delete();
        if (pv && keep) begin
            e.pc    = pc;
            e.instr = instr;
            e.bd    = pc[2];
            e.adel  = pc[3];
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    // Monitor: every accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && fq.pop_valid && fq.pop_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got pc %0h expected no pop", fq.pop_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_entry", 72'({fq.pop_pc, fq.pop_instr, fq.pop_bd, fq.pop_adel}),
                    72'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ok", 72'(fq.req_ok), 72'd0);
        chk("rst_push_ready", 72'(fq.push_ready), 72'd0);
        chk("rst_pop_valid", 72'(fq.pop_valid), 72'd0);
        rst = 1'b0;
        #1;
        chk("rst_count", 72'(count), 72'd0);
        chk("rst_pop_pc", 72'(fq.pop_pc), 72'd0);
        chk("rst_pop_instr", 72'(fq.pop_instr), 72'd0);
        chk("post_rst_req_ok", 72'(fq.req_ok), 72'd1);
        chk("post_rst_push_ready", 72'(fq.push_ready), 72'd1);

        // Fill four entries with decode stalled, then drain in PC order.
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, '0, '0, 0);
            chk("fill_req_ok", 72'(fq.req_ok), 72'd1);
            step();
            drive(0, 1, 0, 0, 32'hBFC0_0000 + 32'(4 * i), 32'h2408_0010 + 32'(i), 1);
            step();
            chk("fill_count", 72'(count), 72'(i + 1));
            chk("fill_pop_valid", 72'(fq.pop_valid), 72'd1);
        end
        chk("full_push_ready", 72'(fq.push_ready), 72'd0);
        chk("full_req_ok", 72'(fq.req_ok), 72'd0);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 1, 0, '0, '0, 0);
            if (k == 1) chk("full_pop_push_ready", 72'(fq.push_ready), 72'd0);
            step();
            chk("drain_count", 72'(count), 72'(4 - k));
        end
        chk("empty_pop_valid", 72'(fq.pop_valid), 72'd0);

        // Credit limit: two requests outstanding blocks req_ok until a response.
        drive(1, 0, 0, 0, '0, '0, 0);
        step();
        drive(1, 0, 0, 0, '0, '0, 0);
        chk("credit_req_ok_1", 72'(fq.req_ok), 72'd1);
        step();
        chk("credit_req_ok_0", 72'(fq.req_ok), 72'd0);
        drive(0, 1, 0, 0, 32'hBFC0_0010, 32'h2409_0001, 1);
        chk("credit_resp_req_ok", 72'(fq.req_ok), 72'd0);
        step();
        chk("credit_back_req_ok", 72'(fq.req_ok), 72'd1);
        drive(0, 1, 0, 0, 32'hBFC0_0014, 32'h2409_0002, 1);
        step();
        drive(1, 0, 0, 0, '0, '0, 0);
        step();
        drive(0, 1, 0, 0, 32'hBFC0_0018, 32'h2409_0003, 1);
        step();
        chk("pre_flush_count", 72'(count), 72'd3);

        // Flush with count=3 and two requests forced in flight.
        drive(1, 0, 0, 0, '0, '0, 0);
        chk("c3_req_ok", 72'(fq.req_ok), 72'd1);
        step();
        drive(1, 0, 0, 0, '0, '0, 0);
        chk("c3_i1_req_ok", 72'(fq.req_ok), 72'd0);
        step();
        drive(0, 0, 1, 1, '0, '0, 0);
        chk("flush_cycle_pop_valid", 72'(fq.pop_valid), 72'd0);
        step();
        chk("flush_count", 72'(count), 72'd0);
        chk("flush_drop_cnt", 72'(u_dut.drop_cnt), 72'd2);
        for (int d = 0; d < 2; d++) begin
            drive(0, 1, 1, 0, 32'hBFC0_0020 + 32'(4 * d), 32'hDEAD_0000 + 32'(d), 0);
            chk("drop_pop_valid", 72'(fq.pop_valid), 72'd0);
            chk("drop_push_ready", 72'(fq.push_ready), 72'd1);
            step();
            chk("drop_count", 72'(count), 72'd0);
        end
        chk("drop_done", 72'(u_dut.drop_cnt), 72'd0);
        drive(1, 0, 0, 0, '0, '0, 0);
        step();
        drive(0, 1, 0, 0, 32'hBFC0_0380, 32'h2408_0380, 1);
        step();
        drive(0, 0, 1, 0, '0, '0, 0);
        chk("after_drop_pop_valid", 72'(fq.pop_valid), 72'd1);
        chk("after_drop_count", 72'(count), 72'd1);
        step();
        chk("after_drop_drain", 72'(count), 72'd0);

        // Flush coinciding with req_fire and push_valid while one request is outstanding.
        drive(1, 0, 0, 0, '0, '0, 0);
        step();
        drive(1, 1, 0, 1, 32'hBFC0_0040, 32'hDEAD_0040, 0);
        step();
        chk("flush_rf_pv_drop", 72'(u_dut.drop_cnt), 72'd1);
        drive(0, 1, 1, 0, 32'hBFC0_0044, 32'hDEAD_0044, 0);
        chk("flush_rf_pv_pop_valid", 72'(fq.pop_valid), 72'd0);
        step();
        chk("flush_rf_pv_drop0", 72'(u_dut.drop_cnt), 72'd0);
        chk("flush_rf_pv_count", 72'(count), 72'd0);
        chk("flush_rf_pv_req_ok", 72'(fq.req_ok), 72'd1);

        // Steady push+pop at count=2; runs the pointers past DEPTH-1.
        drive(1, 0, 0, 0, '0, '0, 0);
        step();
        drive(1, 1, 0, 0, 32'hBFC0_0100, 32'h2410_0000, 1);
        step();
        drive(1, 1, 0, 0, 32'hBFC0_0104, 32'h2410_0001, 1);
        step();
        chk("steady_start_count", 72'(count), 72'd2);
        for (int j = 0; j < 5; j++) begin
            drive(1, 1, 1, 0, 32'hBFC0_0108 + 32'(4 * j), 32'h2410_0002 + 32'(j), 1);
            chk("steady_req_ok", 72'(fq.req_ok), 72'd1);
            step();
            chk("steady_count", 72'(count), 72'd2);
        end
        drive(0, 1, 1, 0, 32'hBFC0_011C, 32'h2410_0007, 1);
        step();
        chk("steady_end_count", 72'(count), 72'd2);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 0, '0, '0, 0);
            step();
        end
        chk("steady_drained", 72'(count), 72'd0);

        // Push into an empty queue with decode ready.
        drive(1, 0, 0, 0, '0, '0, 0);
        step();
        drive(0, 1, 1, 0, 32'hBFC0_0200, 32'h2408_0001, 1);
`ifdef FETCHQ_BYPASS_EN
        chk("bypass_pop_valid", 72'(fq.pop_valid), 72'd1);
        chk("bypass_pop_instr", 72'(fq.pop_instr), 72'h2408_0001);
        step();
        chk("bypass_count", 72'(count), 72'd0);
`else
        chk("nobypass_pop_valid_t", 72'(fq.pop_valid), 72'd0);
        step();
        drive(0, 0, 1, 0, '0, '0, 0);
        chk("nobypass_pop_valid_t1", 72'(fq.pop_valid), 72'd1);
        chk("nobypass_pop_instr", 72'(fq.pop_instr), 72'h2408_0001);
        step();
        chk("nobypass_count", 72'(count), 72'd0);
`endif

        step();
        chk("scoreboard_empty", 72'(exp_q.size()), 72'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
